picosoc_button_debounce: RTL and testbench



---
 rtl/picosoc_button_pkg.sv | 21 ++
 rtl/picosoc_sync2.sv | 24 ++
 rtl/picosoc_button_debounce.sv | 139 +++++++++++++
 tb/tb_picosoc_button_debounce.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_button_pkg.sv
// Shared types and timing constants for the picosoc push-button conditioning path.
package picosoc_button_pkg;

   typedef enum logic [1:0] {
      RELEASED        = 2'd0,
      PRESS_PENDING   = 2'd1,
      PRESSED         = 2'd2,
      RELEASE_PENDING = 2'd3
   } btn_state_t;

   localparam int CLK_HZ                = 27_000_000;
   localparam int CYCLES_PER_MS         = CLK_HZ / 1000;
   localparam int DEF_DEBOUNCE_CYCLES   = 10 * CYCLES_PER_MS;
   localparam int DEF_LONG_PRESS_CYCLES = 1000 * CYCLES_PER_MS;

   // Bits needed for a counter that must hold values 0..max_count.
   function automatic int cnt_width(input int max_count);
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/picosoc_sync2.sv
// Generic two-flop synchronizer for asynchronous pad inputs; RESET_VAL sets
// the level both flops take under synchronous reset.
module picosoc_sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1 <= RESET_VAL;
         q  <= RESET_VAL;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/picosoc_button_debounce.sv
// Push-button conditioner: synchronizer plus counter-qualified debounce FSM.
// Optional one-shot long-press strobe enabled by PICOSOC_BUTTON_LONG_PRESS_EN.
//
// state           | meaning
// RELEASED        | accepted level is released, input agrees
// PRESS_PENDING   | input shows pressed, counting stable cycles
// PRESSED         | accepted level is pressed, input agrees
// RELEASE_PENDING | input shows released, counting stable cycles
module picosoc_button_debounce
   import picosoc_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int ACTIVE_LOW        = 1,
   parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
   input  logic clk,
   input  logic resetn,
   input  logic button_in,
   output logic button_out,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press
);

   localparam logic REL = (ACTIVE_LOW != 0);
   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   btn_state_t    state;
   logic [CW-1:0] cnt;
   logic          s2;
   logic          press_accept;

   picosoc_sync2 #(.RESET_VAL(REL)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (button_in),
      .q      (s2)
   );

   assign press_accept = (state == PRESS_PENDING) && (s2 != REL) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= RELEASED;
         cnt           <= '0;
         button_out    <= REL;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         case (state)
            RELEASED: begin
               if (s2 != REL) begin
                  state <= PRESS_PENDING;
                  cnt   <= CW'(1);
               end else begin
                  cnt <= '0;
               end
            end
            PRESS_PENDING: begin
               if (s2 == REL) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state       <= PRESSED;
                  button_out  <= ~REL;
                  pressed     <= 1'b1;
                  press_pulse <= 1'b1;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (s2 == REL) begin
                  state <= RELEASE_PENDING;
                  cnt   <= CW'(1);
               end else begin
                  cnt <= '0;
               end
            end
            RELEASE_PENDING: begin
               if (s2 != REL) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state         <= RELEASED;
                  button_out    <= REL;
                  pressed       <= 1'b0;
                  release_pulse <= 1'b1;
                  cnt           <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef PICOSOC_BUTTON_LONG_PRESS_EN
   localparam int HW = cnt_width(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [HW-1:0] HCNT_SAT  = HW'(LONG_PRESS_CYCLES);

   logic [HW-1:0] hcnt;

   // Parking at HCNT_SAT guarantees a single strobe per hold; a bounce back
   // from RELEASE_PENDING keeps counting.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hcnt       <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= 1'b0;
         if (press_accept) begin
            hcnt <= '0;
         end else if (state == PRESSED || state == RELEASE_PENDING) begin
            if (hcnt != HCNT_SAT) begin
               hcnt <= hcnt + 1'b1;
            end
            long_press <= (hcnt == HCNT_LAST);
         end
      end
   end
`else
   logic unused_long_cfg;
   assign unused_long_cfg = ^LONG_PRESS_CYCLES ^ press_accept;
   assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_picosoc_button_debounce.sv
// Self-checking bench for picosoc_button_debounce (DEBOUNCE=8, active-low, LONG=20).
module tb_picosoc_button_debounce;

   localparam int   DEB = 8;
   localparam int   LP  = 20;
   localparam logic REL = 1'b1;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic button_in = 1'b1;
   logic button_out, pressed, press_pulse, release_pulse, long_press;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   picosoc_button_debounce #(
      .DEBOUNCE_CYCLES   (DEB),
      .ACTIVE_LOW        (1),
      .LONG_PRESS_CYCLES (LP)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .button_in     (button_in),
      .button_out    (button_out),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press)
   );

   always #5 clk = ~clk;

   // Reference model: pin delayed two clocks, then a level is accepted once it
   // has been seen for DEB consecutive cycles and differs from the current one.
   logic m_s1, m_s2, m_out, m_pp, m_rp, m_lp, m_run_val;
   int   m_run_len, m_hold;

   task automatic model_edge(input logic rb, input logic pin);
      if (!rb) begin
         m_s1 = REL; m_s2 = REL; m_run_val = REL; m_run_len = 0;
         m_out = REL; m_pp = 0; m_rp = 0; m_lp = 0; m_hold = LP;
      end else begin
         m_pp = 0; m_rp = 0; m_lp = 0;
         if (m_out != REL) begin
`ifdef PICOSOC_BUTTON_LONG_PRESS_EN
            m_lp = (m_hold == LP - 1);
`endif
            m_hold++;
         end
         if (m_s2 == m_run_val) m_run_len++;
         else begin
            m_run_val = m_s2;
            m_run_len = 1;
         end
         if (m_run_len >= DEB && m_run_val != m_out) begin
            m_out = m_run_val;
            if (m_out != REL) begin
               m_pp = 1;
               m_hold = 0;
            end else m_rp = 1;
         end
         m_s2 = m_s1;
         m_s1 = pin;
      end
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic rb, input logic pin, input bit do_chk);
      resetn = rb;
      button_in = pin;
      @(posedge clk);
      model_edge(rb, pin);
      #1;
      cyc++;
      if (do_chk) begin
         chk("button_out", button_out, m_out);
         chk("pressed", pressed, m_out != REL);
         chk("press_pulse", press_pulse, m_pp);
         chk("release_pulse", release_pulse, m_rp);
         chk("long_press", long_press, m_lp);
         chk("pulse_excl", press_pulse & release_pulse, 1'b0);
      end
   endtask

   typedef struct {
      logic rb;
      logic pin;
      logic out;
      logic pp;
      logic rp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(logic rb, logic pin, logic out, logic pp, logic rp);
      vec_t v;
      v.rb = rb; v.pin = pin; v.out = out; v.pp = pp; v.rp = rp;
      return v;
   endfunction

   initial begin
      int pp_at, rp_at, lp_at, lp_cnt, pulses;

      // Reset, clean press (accepted on the 10th edge), clean release.
      for (int i = 1; i <= 3; i++)  tbl.push_back(mkv(0, 0, 1, 0, 0));
      for (int i = 1; i <= 14; i++) tbl.push_back(mkv(1, 0, (i >= 10) ? 1'b0 : 1'b1, i == 10, 0));
      for (int i = 1; i <= 12; i++) tbl.push_back(mkv(1, 1, (i >= 10) ? 1'b1 : 1'b0, 0, i == 10));

      foreach (tbl[k]) begin
         step(tbl[k].rb, tbl[k].pin, 0);
         chk("tbl_out", button_out, tbl[k].out);
         chk("tbl_pressed", pressed, ~tbl[k].out);
         chk("tbl_press_pulse", press_pulse, tbl[k].pp);
         chk("tbl_release_pulse", release_pulse, tbl[k].rp);
         chk("tbl_long_press", long_press, 1'b0);
      end

      // Bounce reject: 7 low / 1 high, five times.
      pulses = 0;
      for (int r = 0; r < 5; r++)
         for (int i = 0; i < 8; i++) begin
            step(1, (i == 7) ? 1'b1 : 1'b0, 1);
            pulses += int'(press_pulse) + int'(release_pulse);
         end
      chk_int("bounce_reject_pulses", pulses, 0);
      chk("bounce_reject_out", button_out, 1'b1);

      // Bounce then settle: 0,1,0,0,1 then steady 0.
      for (int i = 0; i < 12; i++) step(1, 1, 1);
      pp_at = -1;
      for (int i = 1; i <= 30; i++) begin
         step(1, (i <= 5) ? ((i == 2 || i == 5) ? 1'b1 : 1'b0) : 1'b0, 1);
         if (press_pulse && pp_at < 0) pp_at = i;
      end
      chk_int("settle_pulse_step", pp_at, 15);

      // Release after an accepted press.
      rp_at = -1;
      for (int i = 1; i <= 15; i++) begin
         step(1, 1, 1);
         if (release_pulse && rp_at < 0) rp_at = i;
         chk("release_no_press_pulse", press_pulse, 1'b0);
      end
      chk_int("release_pulse_step", rp_at, 10);
      chk("release_pressed", pressed, 1'b0);

      // Long hold.
      pp_at = -1; lp_at = -1; lp_cnt = 0;
      for (int i = 1; i <= 45; i++) begin
         step(1, 0, 1);
         if (press_pulse && pp_at < 0) pp_at = i;
         if (long_press) begin
            lp_cnt++;
            if (lp_at < 0) lp_at = i;
         end
      end
      chk_int("hold_press_step", pp_at, 10);
`ifdef PICOSOC_BUTTON_LONG_PRESS_EN
      chk_int("long_press_count", lp_cnt, 1);
      chk_int("long_press_delay", lp_at - pp_at, LP);
`else
      chk_int("long_press_count", lp_cnt, 0);
`endif
      for (int i = 0; i < 15; i++) step(1, 1, 1);

      // Reset mid-bounce discards the partial count.
      for (int i = 0; i < 6; i++) step(1, 0, 1);
      step(0, 0, 1);
      pp_at = -1;
      for (int i = 1; i <= 14; i++) begin
         step(1, 0, 1);
         if (press_pulse && pp_at < 0) pp_at = i;
      end
      chk_int("reset_mid_bounce_step", pp_at, 10);

      // Randomized bursts against the model.
      for (int b = 0; b < 400; b++) begin
         logic lvl;
         int len;
         lvl = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(1, 9));
         if ($urandom_range(0, 39) == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(0, lvl, 1);
         end
         for (int i = 0; i < len; i++) step(1, lvl, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
